pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter block for the single-cycle MIPS datapath.
- Holds the 32-bit instruction address and exposes it plus the sequential address (PC+4).
- Every clock it selects the next address from four sources: sequential, PC-relative branch, absolute jump, or register jump.
- Feeds instruction memory; its PC+4 output feeds the link-register path.

Parameters:
- RESET_ADDR, 32'h0000_0000, value loaded into currentAddress while reset is asserted.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- jumpSteps  input  32  signed branch offset in words (sign-extended immediate)
- selectBranch  input  1  select PC-relative branch target
- selectJump  input  1  select J-type absolute target
- selectJumpR  input  1  select register target
- instruction  input  32  current instruction; bits [25:0] are the jump index
- jumpRAddress  input  32  register-jump target (rs contents)
- currentAddress  output  32  registered PC
- addressPlus4  output  32  combinational currentAddress + 4

Behaviour:
- Reset:
  - reset low forces currentAddress = RESET_ADDR immediately, with no clock required.
  - It holds that value while reset stays low.
  - The first update happens on the first rising clk edge after reset goes high.
- addressPlus4 = currentAddress + 4, modulo 2^32. It is purely combinational; 32'hFFFF_FFFC wraps to 0.
- Branch target = addressPlus4 + (jumpSteps << 2), modulo 2^32.
  - Bits shifted out of [31:30] are discarded.
  - Two's-complement arithmetic, so negative offsets branch backwards.
- Jump target = {addressPlus4[31:28], instruction[25:0], 2'b00}.
- Next-address priority, highest first:
  - selectJumpR=1: jumpRAddress
  - else selectJump=1: jump target
  - else selectBranch=1: branch target
  - else: addressPlus4
- Simultaneous selects resolve strictly by the priority above.
- currentAddress <= next address on every rising clk edge when reset is high. Latency is one cycle from select to new PC. There is no enable or stall.
- jumpRAddress is loaded unmodified; alignment is not checked unless the optional feature is enabled.
- Reset asserted mid-operation overrides any pending select asynchronously.
- No X propagation on outputs after reset.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, registered).
  - On an edge where selectJumpR=1 and jumpRAddress[1:0]!=0, the PC loads {jumpRAddress[31:2],2'b00} and misaligned is set to 1 for that cycle.
  - misaligned is 0 on any other edge; it resets to 0.
- Undefined:
  - No misaligned port.
  - jumpRAddress is loaded raw, including low bits.

Decomposition:
- Package pc_pkg:
  - ADDR_W = 32, PC_INCR = 32'd4, JIDX_W = 26, BR_SHIFT = 2
  - enum next_sel_e {SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_JUMPR} for the internal select encoding
- One sub-module pc_next_sel: combinational adders and priority mux producing nextAddress and addressPlus4. The top holds only the async-reset register plus the optional trap logic.

Test Plan:
- Reset then run: hold reset=0 for 2 cycles -> currentAddress=0 immediately; release with no selects -> 4, 8, 12 on successive edges, and addressPlus4 always equals currentAddress+4.
- Forward branch: at currentAddress=0x14, jumpSteps=100, selectBranch=1 for one edge -> next 0x18+400 = 0x1A8; then +4 resumes to 0x1AC.
- Backward branch: at 0x100, jumpSteps=32'hFFFF_FFFC (-4), selectBranch=1 -> 0x104-16 = 0xF4.
- Jump vs branch priority:
  - at 0x1000_0000, instruction[25:0]=26'h10, selectJump=1 -> 0x1000_0040;
  - repeat with selectBranch=1 also set -> still 0x1000_0040.
- JR precedence and wrap:
  - jumpRAddress=0xFFFF_FFFC, all three selects=1 -> 0xFFFF_FFFC; next edge with no selects -> 0x0000_0000.
  - With PC_MISALIGN_TRAP_EN, jumpRAddress=0x203 -> PC 0x200 and misaligned=1 for one cycle.
- Async reset mid-run: pull reset low between edges at PC=0x40 -> currentAddress=0 before the next edge, stays 0 while low, then 4 on the first edge after release.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared widths and the next-address select encoding for the PC block.
package pc_pkg;
  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] PC_INCR  = 32'd4;
  localparam int unsigned JIDX_W   = 26;
  localparam int unsigned BR_SHIFT = 2;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_JUMPR
  } next_sel_e;
endpackage

// File: rtl/pc_next_unit_if.sv
// Control/address bundle between the datapath control and the PC block.
// With PC_MISALIGN_TRAP_EN defined it also carries the misaligned flag.
interface pc_next_unit_if;
  import pc_pkg::*;

  logic [ADDR_W-1:0] jumpSteps;
  logic              selectBranch;
  logic              selectJump;
  logic              selectJumpR;
  logic [ADDR_W-1:0] instruction;
  logic [ADDR_W-1:0] jumpRAddress;
  logic [ADDR_W-1:0] currentAddress;
  logic [ADDR_W-1:0] addressPlus4;
`ifdef PC_MISALIGN_TRAP_EN
  logic              misaligned;

  modport master (
    output jumpSteps, selectBranch, selectJump, selectJumpR, instruction, jumpRAddress,
    input  currentAddress, addressPlus4, misaligned
  );
  modport slave (
    input  jumpSteps, selectBranch, selectJump, selectJumpR, instruction, jumpRAddress,
    output currentAddress, addressPlus4, misaligned
  );
`else
  modport master (
    output jumpSteps, selectBranch, selectJump, selectJumpR, instruction, jumpRAddress,
    input  currentAddress, addressPlus4
  );
  modport slave (
    input  jumpSteps, selectBranch, selectJump, selectJumpR, instruction, jumpRAddress,
    output currentAddress, addressPlus4
  );
`endif
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC logic: PC+4, branch and jump targets, priority select.
module pc_next_sel
  import pc_pkg::*;
(
  input  logic [ADDR_W-1:0] current_address,
  input  logic [ADDR_W-1:0] jump_steps,
  input  logic              select_branch,
  input  logic              select_jump,
  input  logic              select_jump_r,
  input  logic [ADDR_W-1:0] instruction,
  input  logic [ADDR_W-1:0] jump_r_address,
  output logic [ADDR_W-1:0] next_address,
  output logic [ADDR_W-1:0] address_plus4
);
  next_sel_e         sel;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] jump_target;

  always_comb begin
    address_plus4 = current_address + PC_INCR;
    branch_target = address_plus4 + (jump_steps << BR_SHIFT);
    jump_target   = {address_plus4[ADDR_W-1:JIDX_W+BR_SHIFT],
                     instruction[JIDX_W-1:0], {BR_SHIFT{1'b0}}};
  end

  always_comb begin
    if (select_jump_r)      sel = SEL_JUMPR;
    else if (select_jump)   sel = SEL_JUMP;
    else if (select_branch) sel = SEL_BRANCH;
    else                    sel = SEL_SEQ;
  end

  always_comb begin
    next_address = address_plus4;
    case (sel)
      SEL_JUMPR:  next_address = jump_r_address;
      SEL_JUMP:   next_address = jump_target;
      SEL_BRANCH: next_address = branch_target;
      default:    next_address = address_plus4;
    endcase
  end
endmodule

// File: rtl/pc_next_unit.sv
// Program counter register for the single-cycle MIPS datapath.
// Optional PC_MISALIGN_TRAP_EN: word-aligns register jumps and flags misalignment.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  pc_next_unit_if.slave pc
);
  logic [ADDR_W-1:0] currentAddress_q;
  logic [ADDR_W-1:0] currentAddress_d;
  logic [ADDR_W-1:0] next_address;
  logic [ADDR_W-1:0] address_plus4;

  pc_next_sel u_next_sel (
    .current_address (currentAddress_q),
    .jump_steps      (pc.jumpSteps),
    .select_branch   (pc.selectBranch),
    .select_jump     (pc.selectJump),
    .select_jump_r   (pc.selectJumpR),
    .instruction     (pc.instruction),
    .jump_r_address  (pc.jumpRAddress),
    .next_address    (next_address),
    .address_plus4   (address_plus4)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic misaligned_q;
  logic misaligned_d;

  // Register jump wins priority, so clearing the low bits of the muxed result aligns it.
  always_comb begin
    currentAddress_d = next_address;
    misaligned_d     = 1'b0;
    if (pc.selectJumpR && (pc.jumpRAddress[1:0] != 2'b00)) begin
      currentAddress_d = {next_address[ADDR_W-1:2], 2'b00};
      misaligned_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end

  assign pc.misaligned = misaligned_q;
`else
  always_comb begin
    currentAddress_d = next_address;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) currentAddress_q <= RESET_ADDR;
    else        currentAddress_q <= currentAddress_d;
  end

  assign pc.currentAddress = currentAddress_q;
  assign pc.addressPlus4   = address_plus4;
endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed test-plan cases plus random selects.
module tb_pc_next_unit;
  logic clk;
  logic reset;

  pc_next_unit_if bus();

  pc_next_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .pc    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_pc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one set of inputs (caller is at a negedge) and queue the PC expected after the next edge.
  task automatic apply(input logic jr, input logic j, input logic b, input logic [31:0] steps,
                       input logic [31:0] instr, input logic [31:0] jra);
    logic [31:0] seq;
    exp_t        e;
    bus.selectJumpR  = jr;
    bus.selectJump   = j;
    bus.selectBranch = b;
    bus.jumpSteps    = steps;
    bus.instruction  = instr;
    bus.jumpRAddress = jra;
    seq   = model_pc + 32'd4;
    e.mis = 1'b0;
    if (jr) begin
      e.pc = jra;
`ifdef PC_MISALIGN_TRAP_EN
      if (jra % 4 != 0) begin
        e.pc  = jra - (jra % 4);
        e.mis = 1'b1;
      end
`endif
    end else if (j)
      e.pc = (seq & 32'hF000_0000) + (instr % 32'h0400_0000) * 4;
    else if (b)
      e.pc = seq + steps * 4;
    else
      e.pc = seq;
    model_pc = e.pc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic jr, input logic j, input logic b, input logic [31:0] steps,
                       input logic [31:0] instr, input logic [31:0] jra);
    @(negedge clk);
    apply(jr, j, b, steps, instr, jra);
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
  endtask

  // Monitor: the PC presents a new value after every edge; compare against the queued model result.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check32("pc", bus.currentAddress, e.pc);
      check32("pc4", bus.addressPlus4, e.pc + 32'd4);
`ifdef PC_MISALIGN_TRAP_EN
      check32("mis", {31'd0, bus.misaligned}, {31'd0, e.mis});
`endif
    end
  end

  initial begin
    reset            = 1'b0;
    model_pc         = 32'h0;
    bus.selectJumpR  = 1'b0;
    bus.selectJump   = 1'b0;
    bus.selectBranch = 1'b0;
    bus.jumpSteps    = '0;
    bus.instruction  = '0;
    bus.jumpRAddress = '0;
    #1;
    check32("reset_pc", bus.currentAddress, 32'h0);
    check32("reset_pc4", bus.addressPlus4, 32'h4);
    repeat (2) @(posedge clk);
    #1;
    check32("reset_hold", bus.currentAddress, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
    check32("reset_mis", {31'd0, bus.misaligned}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    apply(0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0);

    // Forward branch, then sequential resume
    issue(1, 0, 0, 0, 0, 32'h14);
    issue(0, 0, 1, 32'd100, 0, 0);
    issue(0, 0, 0, 0, 0, 0);
    // Backward branch
    issue(1, 0, 0, 0, 0, 32'h100);
    issue(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    // Jump, then jump with branch also set
    issue(1, 0, 0, 0, 0, 32'h1000_0000);
    issue(0, 1, 0, 32'd7, 32'h0000_0010, 0);
    issue(1, 0, 0, 0, 0, 32'h1000_0000);
    issue(0, 1, 1, 32'd7, 32'hFC00_0010, 0);
    // Register jump over everything, then wrap
    issue(1, 1, 1, 32'd3, 32'h0000_0123, 32'hFFFF_FFFC);
    issue(0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 32'h203);
    issue(0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 32'h40);
    drain();

    // Asynchronous reset between edges
    check32("pre_async", bus.currentAddress, 32'h40);
    reset = 1'b0;
    #1;
    check32("async_pc", bus.currentAddress, 32'h0);
    check32("async_pc4", bus.addressPlus4, 32'h4);
    @(posedge clk);
    #1;
    check32("async_hold", bus.currentAddress, 32'h0);
    @(negedge clk);
    reset    = 1'b1;
    model_pc = 32'h0;
    apply(0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] steps;
      steps = $urandom();
      if ($urandom_range(0, 1) == 1) steps = $signed(steps) >>> $urandom_range(8, 30);
      issue($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            steps, $urandom(), $urandom());
    end
    issue(0, 0, 0, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
